eoc_readout_scheduler: RTL and testbench
========================================

# eoc_readout_scheduler

End-of-column readout scheduler for the pixel array. It shares one readout path among NUM_COL double-column chains using round-robin arbitration. For the granted column it latches the 26-bit column word, pulses that column's shake_hands_col acknowledge so the chain advances, then waits a settle interval before arbitrating again. Captured words are tagged with the column index and buffered in a show-ahead FIFO for the downstream serializer.

## Interface
Parameters:
- NUM_COL, 4, number of double-column chains (2..8)
- COL_W, 3, column-index tag width; must satisfy 2^COL_W >= NUM_COL
- FIFO_DEPTH, 8, output FIFO depth; a power of 2, at least 2
- SETTLE_CYC, 2, idle cycles after an acknowledge, so the chain can present its next word (1..15)

Ports:
- clk_40MHz  in  1  the single clock; all logic runs on its rising edge
- rst_n  in  1  reset; synchronous, active-low
- readout_en  in  1  permits new grants; normally driven by the inverse of shutter
- col_req  in  NUM_COL  bit c high means column c presents a valid word on col_data
- col_data  in  26*NUM_COL  column c's word is on bits [26c+25:26c]
- shake_hands_col  out  NUM_COL  one-cycle acknowledge to the granted column
- out_data  out  COL_W+26  {column index, word} at the FIFO head
- out_valid  out  1  FIFO not empty
- out_ready  in  1  downstream pop; a pop happens when out_valid and out_ready are both high
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy
- busy  out  1  high when the state machine is not in IDLE or the FIFO is not empty

## Operation
- The state machine has three states: IDLE, ACK and SETTLE.
- IDLE grant condition: readout_en=1, (col_req != 0) and fifo_count < FIFO_DEPTH.
  - The column granted (g) is the first requesting column at or after rr_ptr, searching upward and wrapping modulo NUM_COL.
  - On that clock edge, {g, col_data[g]} is written into the FIFO.
  - rr_ptr is set to (g+1) mod NUM_COL.
  - The state moves to ACK.
- ACK lasts exactly one cycle.
  - shake_hands_col has only bit g high; every other bit is 0.
  - The state moves to SETTLE.
- SETTLE lasts SETTLE_CYC cycles, counted by a down-counter.
  - shake_hands_col is 0 and col_req is ignored.
  - The state then returns to IDLE.
- If readout_en falls during ACK or SETTLE, the transaction still completes. No new grant is issued while readout_en is low.
- FIFO behaviour:
  - It is show-ahead: out_data always shows the head entry.
  - Write and read pointers wrap modulo FIFO_DEPTH.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - A pop is ignored when the FIFO is empty.
  - Overflow cannot occur, because grants are blocked when the FIFO is full.
- Full-FIFO case: grants are blocked only when fifo_count = FIFO_DEPTH at the IDLE decision. If a pop happens in that same cycle, the grant waits until the next cycle's evaluation.
- Reset values, with rst_n=0 sampled at a rising edge:
  - State machine returns to IDLE; rr_ptr=0; settle counter=0.
  - FIFO pointers and fifo_count are cleared.
  - shake_hands_col=0, out_valid=0, busy=0.
  - out_data is 0 (the FIFO storage itself need not be cleared).
- Reset mid-transaction: an in-progress ACK is aborted and shake_hands_col drops the next cycle. Any word already pushed is discarded.

## Timing
- Cycle N: IDLE sees a grant condition. The FIFO write happens at the edge ending cycle N.
- Cycle N+1:
  - shake_hands_col[g]=1 (the ACK state).
  - out_valid=1 if the FIFO was empty.
  - fifo_count has already incremented.
- Cycles N+2 .. N+1+SETTLE_CYC: the SETTLE state.
- Cycle N+2+SETTLE_CYC: IDLE, and the next grant is possible.
- Maximum throughput is one word per SETTLE_CYC+2 cycles (one word per 4 cycles at the defaults).
- Columns must keep col_data stable while col_req is high. They must drop or refresh col_req within SETTLE_CYC cycles after the acknowledge.
- A pop takes effect at the edge where out_valid and out_ready are both high. The new head, or out_valid=0, appears in the next cycle.

## Test plan
- **Reset check:** hold rst_n=0 for 3 cycles with all col_req set. Required: shake_hands_col=0, out_valid=0, fifo_count=0, busy=0.
- **Single request:** col_req=4'b0100, col_data[2]=26'h2ABCDEF. Required:
  - out_data={3'd2, 26'h2ABCDEF} with out_valid=1 one cycle after the grant.
  - shake_hands_col=4'b0100 for exactly one cycle, then 2 settle cycles.
- **Round-robin:** hold col_req=4'b1111 with out_ready=1. Required:
  - Grant order 0,1,2,3,0,... with a 4-cycle spacing between shake_hands_col pulses.
  - After a grant of column 3, rr_ptr=0.
- **FIFO full:** col_req=4'b0001 held with out_ready=0. Required:
  - Exactly 8 pushes, after which fifo_count=8 and no further shake_hands_col pulses.
  - After a 1-cycle out_ready pulse, fifo_count=7 and one more grant follows, bringing fifo_count back to 8.
- **readout_en drop:** deassert readout_en on the cycle after a grant. Required: that ACK and SETTLE complete, and no further grant is issued while readout_en is low.
- **Simultaneous push and pop:** with fifo_count=3, a push and a pop in the same cycle leave fifo_count at 3. Head order is preserved first-in, first-out.

Source files
------------

// File: rtl/eoc_readout_scheduler.sv
// End-of-column readout scheduler: round-robin grant over NUM_COL chains,
// one-cycle acknowledge, settle wait, and a show-ahead output FIFO.
`timescale 1ns/1ps

module eoc_readout_scheduler #(
    parameter int NUM_COL    = 4,
    parameter int COL_W      = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic                          clk_40MHz,
    input  logic                          rst_n,
    input  logic                          readout_en,
    input  logic [NUM_COL-1:0]            col_req,
    input  logic [26*NUM_COL-1:0]         col_data,
    output logic [NUM_COL-1:0]            shake_hands_col,
    output logic [COL_W+25:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    // state  | meaning
    // IDLE   | waiting for a grant condition
    // ACK    | one-cycle acknowledge to the granted column
    // SETTLE | down-count while the chain presents its next word

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = COL_W + 26;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [COL_W-1:0] rr_ptr, rr_next;
    logic [COL_W-1:0] gnt_col, gnt_next;
    logic [3:0]       settle_cnt, settle_next;

    logic             scan_hit;
    logic [COL_W-1:0] scan_idx;
    logic [COL_W:0]   scan_pos;
    logic             scan_bit;

    logic             grant;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [DW-1:0]    push_word;

    logic [DW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // First requesting column at or after rr_ptr, wrapping modulo NUM_COL.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        scan_pos = '0;
        scan_bit = 1'b0;
        for (int i = 0; i < NUM_COL; i++) begin
            scan_pos = {1'b0, rr_ptr} + (COL_W+1)'(i);
            if (scan_pos >= (COL_W+1)'(NUM_COL)) begin
                scan_pos = scan_pos - (COL_W+1)'(NUM_COL);
            end
            scan_bit = |(col_req & (NUM_COL'(1) << scan_pos));
            if (!scan_hit && scan_bit) begin
                scan_hit = 1'b1;
                scan_idx = scan_pos[COL_W-1:0];
            end
        end
    end

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign grant     = (state == IDLE) && readout_en && scan_hit && !full;
    assign push      = grant;
    assign pop       = out_ready && !empty;
    assign push_word = {scan_idx, 26'(col_data >> (26 * scan_idx))};

    always_comb begin
        state_next      = state;
        rr_next         = rr_ptr;
        gnt_next        = gnt_col;
        settle_next     = settle_cnt;
        shake_hands_col = '0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = ACK;
                    gnt_next   = scan_idx;
                    rr_next    = (scan_idx == COL_W'(NUM_COL-1)) ? '0 : scan_idx + COL_W'(1);
                end
            end
            ACK: begin
                shake_hands_col = NUM_COL'(1) << gnt_col;
                state_next      = SETTLE;
                settle_next     = 4'(SETTLE_CYC - 1);
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    settle_next = settle_cnt - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_40MHz) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt_col    <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_next;
            rr_ptr     <= rr_next;
            gnt_col    <= gnt_next;
            settle_cnt <= settle_next;
        end
    end

    // Storage is not reset; out_data is masked while the FIFO is empty.
    always_ff @(posedge clk_40MHz) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk_40MHz) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_data   = empty ? '0 : mem[rd_ptr];
    assign out_valid  = !empty;
    assign fifo_count = count;
    assign busy       = (state != IDLE) || !empty;

endmodule

// File: tb/tb_eoc_readout_scheduler.sv
// Directed bench for eoc_readout_scheduler: reset, single grant, round-robin,
// FIFO full, readout_en drop, push/pop overlap and mid-transaction reset.
`timescale 1ns/1ps

module tb_eoc_readout_scheduler;

    logic         clk_40MHz = 1'b0;
    logic         rst_n;
    logic         readout_en;
    logic [3:0]   col_req;
    logic [103:0] col_data;
    logic [3:0]   shake_hands_col;
    logic [28:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   fifo_count;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int pulses;

    localparam logic [25:0] W0 = 26'h0123456;
    localparam logic [25:0] W1 = 26'h1111111;
    localparam logic [25:0] W2 = 26'h2ABCDEF;
    localparam logic [25:0] W3 = 26'h3FEDCBA;

    eoc_readout_scheduler #(
        .NUM_COL(4), .COL_W(3), .FIFO_DEPTH(8), .SETTLE_CYC(2)
    ) dut (
        .clk_40MHz      (clk_40MHz),
        .rst_n          (rst_n),
        .readout_en     (readout_en),
        .col_req        (col_req),
        .col_data       (col_data),
        .shake_hands_col(shake_hands_col),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_count     (fifo_count),
        .busy           (busy)
    );

    always #12.5 clk_40MHz = ~clk_40MHz;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [28:0] exp_word(input int c);
        case (c)
            0:       return {3'd0, W0};
            1:       return {3'd1, W1};
            2:       return {3'd2, W2};
            default: return {3'd3, W3};
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_40MHz);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        col_req   = 4'b0000;
        out_ready = 1'b0;
        readout_en = 1'b1;
        rst_n     = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        readout_en = 1'b1;
        col_req    = 4'b1111;
        out_ready  = 1'b0;
        col_data   = {W3, W2, W1, W0};

        // reset with all columns requesting
        tick(3);
        check("rst_shake", 64'(shake_hands_col), 64'h0);
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_count", 64'(fifo_count), 64'h0);
        check("rst_busy",  64'(busy), 64'h0);
        check("rst_data",  64'(out_data), 64'h0);

        // single request on column 2
        rst_n   = 1'b1;
        col_req = 4'b0100;
        tick(1);
        check("single_ack",   64'(shake_hands_col), 64'h4);
        check("single_valid", 64'(out_valid), 64'h1);
        check("single_data",  64'(out_data), 64'(exp_word(2)));
        check("single_count", 64'(fifo_count), 64'h1);
        col_req = 4'b0000;
        tick(1);
        check("single_settle1", 64'(shake_hands_col), 64'h0);
        check("single_busy",    64'(busy), 64'h1);
        tick(1);
        check("single_settle2", 64'(shake_hands_col), 64'h0);
        out_ready = 1'b1;
        tick(1);
        check("single_pop_valid", 64'(out_valid), 64'h0);
        check("single_pop_busy",  64'(busy), 64'h0);
        out_ready = 1'b0;

        // round-robin with continuous drain
        do_reset();
        col_req   = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            tick(1);
            if (k % 4 == 0) begin
                check($sformatf("rr_ack%0d", k), 64'(shake_hands_col), 64'(4'b0001 << ((k / 4) % 4)));
                check($sformatf("rr_data%0d", k), 64'(out_data), 64'(exp_word((k / 4) % 4)));
                check($sformatf("rr_count%0d", k), 64'(fifo_count), 64'h1);
            end else begin
                check($sformatf("rr_idle%0d", k), 64'(shake_hands_col), 64'h0);
            end
        end

        // FIFO full with column 0 requesting and no drain
        do_reset();
        col_req = 4'b0001;
        pulses  = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (shake_hands_col != 4'b0000) pulses++;
        end
        check("full_pulses", 64'(pulses), 64'd8);
        check("full_count",  64'(fifo_count), 64'd8);
        check("full_head",   64'(out_data), 64'(exp_word(0)));
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("full_pop_count", 64'(fifo_count), 64'd7);
        check("full_pop_shake", 64'(shake_hands_col), 64'h0);
        tick(1);
        check("full_regrant_ack",   64'(shake_hands_col), 64'h1);
        check("full_regrant_count", 64'(fifo_count), 64'd8);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (shake_hands_col != 4'b0000) pulses++;
        end
        check("full_no_more", 64'(pulses), 64'd0);

        // readout_en falls right after a grant
        do_reset();
        col_req = 4'b0010;
        tick(1);
        check("en_ack", 64'(shake_hands_col), 64'h2);
        readout_en = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (shake_hands_col != 4'b0000) pulses++;
        end
        check("en_low_pulses", 64'(pulses), 64'd0);
        check("en_low_count",  64'(fifo_count), 64'd1);
        readout_en = 1'b1;
        tick(1);
        check("en_regrant_ack",   64'(shake_hands_col), 64'h2);
        check("en_regrant_count", 64'(fifo_count), 64'd2);

        // reset during ACK discards everything
        rst_n = 1'b0;
        tick(1);
        check("midrst_shake", 64'(shake_hands_col), 64'h0);
        check("midrst_count", 64'(fifo_count), 64'h0);
        check("midrst_valid", 64'(out_valid), 64'h0);

        // push and pop in the same cycle at fifo_count=3
        do_reset();
        col_req = 4'b1111;
        tick(12);
        check("pp_pre_count", 64'(fifo_count), 64'd3);
        check("pp_pre_head",  64'(out_data), 64'(exp_word(0)));
        out_ready = 1'b1;
        tick(1);
        col_req = 4'b0000;
        check("pp_ack",   64'(shake_hands_col), 64'h8);
        check("pp_count", 64'(fifo_count), 64'd3);
        check("pp_head1", 64'(out_data), 64'(exp_word(1)));
        tick(1);
        check("pp_head2",  64'(out_data), 64'(exp_word(2)));
        check("pp_count2", 64'(fifo_count), 64'd2);
        tick(1);
        check("pp_head3",  64'(out_data), 64'(exp_word(3)));
        check("pp_count1", 64'(fifo_count), 64'd1);
        tick(1);
        check("pp_empty", 64'(out_valid), 64'h0);
        check("pp_count0", 64'(fifo_count), 64'd0);
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
